// File: rtl/hack_cpu_pkg.sv
// Shared definitions for the multi-cycle Hack CPU: FSM states, instruction
// bit positions and jump codes.
package hack_cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    MREAD  = 2'd1,
    EXEC   = 2'd2,
    MWRITE = 2'd3
  } state_t;

  localparam int A_BIT      = 12;
  localparam int ALU_HI     = 11;
  localparam int ALU_LO     = 6;
  localparam int DEST_A_BIT = 5;
  localparam int DEST_D_BIT = 4;
  localparam int DEST_M_BIT = 3;

  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT   = 3'b001;
  localparam logic [2:0] JEQ   = 3'b010;
  localparam logic [2:0] JGE   = 3'b011;
  localparam logic [2:0] JLT   = 3'b100;
  localparam logic [2:0] JNE   = 3'b101;
  localparam logic [2:0] JLE   = 3'b110;
  localparam logic [2:0] JMP   = 3'b111;

  function automatic logic jump_taken(input logic [2:0] jcode, input logic zr,
                                      input logic ng);
    jump_taken = 1'b0;
    case (jcode)
      JNULL: jump_taken = 1'b0;
      JGT:   jump_taken = !zr && !ng;
      JEQ:   jump_taken = zr;
      JGE:   jump_taken = !ng;
      JLT:   jump_taken = ng;
      JNE:   jump_taken = !zr;
      JLE:   jump_taken = zr || ng;
      JMP:   jump_taken = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_w.sv
// Hack ALU: zx,nx,zy,ny,f,no control on ctrl[5:0], with zero and negative flags.
module alu_w #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] xs, ys, r;

  always_comb begin
    xs = ctrl[5] ? '0 : x;
    if (ctrl[4]) xs = ~xs;
    ys = ctrl[3] ? '0 : y;
    if (ctrl[2]) ys = ~ys;
    r = ctrl[1] ? (xs + ys) : (xs & ys);
    if (ctrl[0]) r = ~r;
    out = r;
    zr  = (r == '0);
    ng  = r[WIDTH-1];
  end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU (FETCH/MREAD/EXEC/MWRITE). Define HACK_CPU_MEM_WAIT_EN
// to make MREAD/MWRITE wait for dmem_ack; otherwise they take one cycle each.
module hack_cpu_mc
  import hack_cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PC_W  = 15
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [WIDTH-1:0] imem_data,
  output logic [PC_W-1:0]  dmem_addr,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic [PC_W-1:0]  pc,
  output logic             retire,
  output state_t           dbg_state
);

  state_t state, state_nxt;
  logic [WIDTH-1:0] ir, a_reg, d_reg, a_snap, d_snap, m_reg;
  logic [WIDTH-1:0] alu_y, alu_out;
  logic             alu_zr, alu_ng;
  logic             is_c, dest_m, take_jump, mem_done;
  logic [PC_W-1:0]  pc_inc;

`ifdef HACK_CPU_MEM_WAIT_EN
  assign mem_done = dmem_ack;
`else
  logic unused_ack;
  assign unused_ack = dmem_ack;
  assign mem_done   = 1'b1;
`endif

  assign is_c      = ir[WIDTH-1];
  assign dest_m    = is_c & ir[DEST_M_BIT];
  assign alu_y     = ir[A_BIT] ? m_reg : a_snap;
  assign take_jump = is_c & jump_taken(ir[2:0], alu_zr, alu_ng);
  assign pc_inc    = pc + 1'b1;
  assign imem_addr = pc;
  // Data accesses always use the A value seen at fetch, not one updated in EXEC.
  assign dmem_addr = a_snap[PC_W-1:0];
  assign dbg_state = state;

  alu_w #(.WIDTH(WIDTH)) u_alu (
    .x    (d_snap),
    .y    (alu_y),
    .ctrl (ir[ALU_HI:ALU_LO]),
    .out  (alu_out),
    .zr   (alu_zr),
    .ng   (alu_ng)
  );

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid)
          state_nxt = (imem_data[WIDTH-1] && imem_data[A_BIT]) ? MREAD : EXEC;
      end
      MREAD: begin
        dmem_re = 1'b1;
        if (mem_done) state_nxt = EXEC;
      end
      EXEC: begin
        retire    = !dest_m;
        state_nxt = dest_m ? MWRITE : FETCH;
      end
      MWRITE: begin
        dmem_we = 1'b1;
        if (mem_done) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
    // An access in flight when reset arrives is dropped immediately.
    if (reset) begin
      dmem_re = 1'b0;
      dmem_we = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= '0;
      a_reg      <= '0;
      d_reg      <= '0;
      ir         <= '0;
      a_snap     <= '0;
      d_snap     <= '0;
      m_reg      <= '0;
      dmem_wdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: begin
          if (imem_valid) begin
            ir     <= imem_data;
            a_snap <= a_reg;
            d_snap <= d_reg;
          end
        end
        MREAD: begin
          if (mem_done) m_reg <= dmem_rdata;
        end
        EXEC: begin
          if (!is_c) begin
            a_reg <= {1'b0, ir[WIDTH-2:0]};
            pc    <= pc_inc;
          end else begin
            if (ir[DEST_A_BIT]) a_reg <= alu_out;
            if (ir[DEST_D_BIT]) d_reg <= alu_out;
            if (ir[DEST_M_BIT]) dmem_wdata <= alu_out;
            pc <= take_jump ? a_snap[PC_W-1:0] : pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
